skip_slice_packer: RTL and testbench

Writer-side counterpart of the layer-6 skip-slice selector. Collects four 4-word (64-bit) skip slices, each tagged with the same 3-bit depth code the selector decodes, into one 16-word (256-bit) skip vector. Presents the assembled vector on a valid/ready output. Sits between the layer-6 skip producer and the skip storage that later feeds the slice selector, so that selector slice k reads back exactly what was written here under depth code k.

---
 rtl/skip_pkg.sv | 27 ++
 rtl/skip_quarter_dec.sv | 25 ++
 rtl/skip_slice_packer.sv | 118 +++++++++++
 tb/tb_skip_slice_packer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/skip_pkg.sv
// Shared definitions for the layer-6 skip path: vector geometry and the
// depth-code to quarter mapping used by both the packer and the slice selector.
package skip_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned SLICE_WORDS = 4;
    localparam int unsigned NUM_SLICES  = 4;
    localparam int unsigned SLICE_W     = WORD_W * SLICE_WORDS;
    localparam int unsigned SKIP_W      = SLICE_W * NUM_SLICES;

    typedef logic [SLICE_W-1:0] skip_slice_t;
    typedef logic [SKIP_W-1:0]  skip_vec_t;

    // Depth code 00 denotes the deepest slice, so it lands in the top quarter.
    function automatic logic [1:0] quarter_of(input logic [1:0] depth);
        logic [1:0] q;
        q = 2'd3;
        unique case (depth)
            2'b01:   q = 2'd0;
            2'b10:   q = 2'd1;
            2'b11:   q = 2'd2;
            default: q = 2'd3;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/skip_quarter_dec.sv
// Depth code to one-hot quarter write-enable; bit 2 of the code is a don't-care.
module skip_quarter_dec
    import skip_pkg::*;
(
    input  logic [2:0] depth,
    output logic [3:0] quarter_we
);

    logic [1:0] quarter;
    logic       unused_depth_msb;

    assign unused_depth_msb = depth[2];
    assign quarter          = quarter_of(depth[1:0]);

    always_comb begin
        quarter_we = 4'b0000;
        unique case (quarter)
            2'd0:    quarter_we = 4'b0001;
            2'd1:    quarter_we = 4'b0010;
            2'd2:    quarter_we = 4'b0100;
            default: quarter_we = 4'b1000;
        endcase
    end

endmodule

// File: rtl/skip_slice_packer.sv
// Packs four depth-tagged 64-bit skip slices into one 256-bit skip vector and
// presents it on a valid/ready output, holding off the producer when it backs up.
module skip_slice_packer #(
    parameter int unsigned WORD_W      = skip_pkg::WORD_W,
    parameter int unsigned SLICE_WORDS = skip_pkg::SLICE_WORDS,
    parameter int unsigned NUM_SLICES  = skip_pkg::NUM_SLICES
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [WORD_W*SLICE_WORDS-1:0]             slice_in,
    input  logic [2:0]                                depth_in,
    input  logic                                      slice_valid,
    output logic                                      slice_ready,
    output logic [WORD_W*SLICE_WORDS*NUM_SLICES-1:0]  skip_out,
    output logic                                      skip_valid,
    input  logic                                      skip_ready,
    output logic                                      dup_err,
    input  logic                                      err_clr
);

    localparam int unsigned SliceW = WORD_W * SLICE_WORDS;
    localparam int unsigned VecW   = SliceW * NUM_SLICES;

    logic [VecW-1:0] acc_q, acc_d;
    logic [3:0]      mask_q, mask_d, mask_new;
    logic            hold_q, hold_d;
    logic [VecW-1:0] out_q, out_d;
    logic            valid_q, valid_d;
    logic            dup_q, dup_d;

    logic [3:0] quarter_we;
    logic       accept;
    logic       out_fire;
    logic       out_free;
    logic       dup_write;
    logic       complete;

    skip_quarter_dec u_quarter_dec (
        .depth      (depth_in),
        .quarter_we (quarter_we)
    );

    assign slice_ready = !hold_q;
    assign accept      = slice_valid && slice_ready;
    assign out_fire    = valid_q && skip_ready;
    assign out_free    = !valid_q || skip_ready;

    assign mask_new  = accept ? (mask_q | quarter_we) : mask_q;
    assign dup_write = accept && |(mask_q & quarter_we);
    assign complete  = accept && (mask_new == 4'hF);

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && quarter_we[i]) begin
                acc_d[i*SliceW +: SliceW] = slice_in;
            end
        end
    end

    // hold and accept are mutually exclusive, so the branches below never overlap.
    always_comb begin
        mask_d  = mask_new;
        hold_d  = hold_q;
        out_d   = out_q;
        valid_d = valid_q;

        if (complete) begin
            if (out_free) begin
                out_d   = acc_d;
                valid_d = 1'b1;
                mask_d  = 4'h0;
            end else begin
                hold_d  = 1'b1;
            end
        end else if (hold_q && out_fire) begin
            out_d   = acc_q;
            valid_d = 1'b1;
            mask_d  = 4'h0;
            hold_d  = 1'b0;
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    // A duplicate in the same cycle as err_clr must still be reported.
    always_comb begin
        dup_d = dup_q;
        if (dup_write) begin
            dup_d = 1'b1;
        end else if (err_clr) begin
            dup_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mask_q  <= 4'h0;
            hold_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            dup_q   <= dup_d;
        end
    end

    assign skip_out   = out_q;
    assign skip_valid = valid_q;
    assign dup_err    = dup_q;

endmodule

// File: tb/tb_skip_slice_packer.sv
// Self-checking bench for skip_slice_packer: directed scenarios plus random traffic,
// checked against a model that views the packer as a fill buffer feeding a 2-entry queue.
module tb_skip_slice_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  slice_in = '0;
    logic [2:0]   depth_in = '0;
    logic         slice_valid = 1'b0;
    logic         slice_ready;
    logic [255:0] skip_out;
    logic         skip_valid;
    logic         skip_ready = 1'b0;
    logic         dup_err;
    logic         err_clr = 1'b0;

    always #5 clk = ~clk;

    skip_slice_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .slice_in    (slice_in),
        .depth_in    (depth_in),
        .slice_valid (slice_valid),
        .slice_ready (slice_ready),
        .skip_out    (skip_out),
        .skip_valid  (skip_valid),
        .skip_ready  (skip_ready),
        .dup_err     (dup_err),
        .err_clr     (err_clr)
    );

    // Model: quarters being filled, which are filled, and vectors awaiting the consumer.
    logic [63:0]  m_quarter [4];
    logic [3:0]   m_filled;
    logic [255:0] m_pending [$];
    logic         m_err;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] DA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] DB = 64'hBBBB_BBBB_BBBB_BBBB;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_pending.delete();
        m_filled = 4'h0;
        m_err    = 1'b0;
        for (int i = 0; i < 4; i++) m_quarter[i] = '0;
    endtask

    // Called at a negedge: drive, compare pre-edge outputs, advance the model, clock.
    task automatic step(input logic v, input logic [2:0] d, input logic [63:0] data,
                        input logic rdy, input logic clr);
        logic acc;
        logic pop;
        logic dupf;
        int   q;
        slice_valid = v;
        depth_in    = d;
        slice_in    = data;
        skip_ready  = rdy;
        err_clr     = clr;
        #1;
        chk("slice_ready", 256'(slice_ready), 256'(m_pending.size() < 2));
        chk("skip_valid", 256'(skip_valid), 256'(m_pending.size() > 0));
        if (m_pending.size() > 0) chk("skip_out", skip_out, m_pending[0]);
        chk("dup_err", 256'(dup_err), 256'(m_err));

        acc  = v && (m_pending.size() < 2);
        pop  = (m_pending.size() > 0) && rdy;
        dupf = 1'b0;
        if (acc) begin
            q = (int'(d[1:0]) + 3) % 4;
            dupf = m_filled[q];
            m_quarter[q] = data;
            m_filled[q]  = 1'b1;
        end
        if (dupf) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        if (pop) void'(m_pending.pop_front());
        if (acc && m_filled == 4'hF) begin
            m_pending.push_back({m_quarter[3], m_quarter[2], m_quarter[1], m_quarter[0]});
            m_filled = 4'h0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs are checked while it is low.
    task automatic do_reset();
        slice_valid = 1'b0;
        err_clr     = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_skip_valid", 256'(skip_valid), 256'(0));
        chk("rst_skip_out", skip_out, 256'(0));
        chk("rst_dup_err", 256'(dup_err), 256'(0));
        chk("rst_slice_ready", 256'(slice_ready), 256'(1));
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [255:0] v1;
        int           ready_drops;
        int           valid_highs;
        v1 = {D4, D3, D2, D1};
        model_clear();
        @(negedge clk);
        do_reset();

        // In-order codes, consumer ready.
        step(1'b1, 3'b001, D1, 1'b1, 1'b0);
        step(1'b1, 3'b010, D2, 1'b1, 1'b0);
        step(1'b1, 3'b011, D3, 1'b1, 1'b0);
        step(1'b1, 3'b000, D4, 1'b1, 1'b0);
        #1;
        chk("t1_vector", skip_out, v1);
        chk("t1_valid", 256'(skip_valid), 256'(1));

        // Shuffled order with bit 2 set.
        step(1'b1, 3'b100, D4, 1'b1, 1'b0);
        step(1'b1, 3'b111, D3, 1'b1, 1'b0);
        step(1'b1, 3'b101, D1, 1'b1, 1'b0);
        step(1'b1, 3'b110, D2, 1'b1, 1'b0);
        #1;
        chk("t2_vector", skip_out, v1);

        // Backpressure: vectors A and B with the consumer stalled.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 3'((i % 4) + 1), {8{8'(8'hA0 + i)}}, 1'b0, 1'b0);
        end
        step(1'b1, 3'b001, D1, 1'b0, 1'b0);
        step(1'b1, 3'b001, D1, 1'b0, 1'b0);
        #1;
        chk("t3_blocked", 256'(slice_ready), 256'(0));
        step(1'b0, 3'b000, '0, 1'b1, 1'b0);
        step(1'b0, 3'b000, '0, 1'b1, 1'b0);
        step(1'b0, 3'b000, '0, 1'b1, 1'b0);

        // Duplicate quarter write, then clear.
        step(1'b1, 3'b010, DA, 1'b1, 1'b0);
        step(1'b1, 3'b010, DB, 1'b1, 1'b0);
        step(1'b1, 3'b001, D1, 1'b1, 1'b0);
        step(1'b1, 3'b011, D3, 1'b1, 1'b0);
        step(1'b1, 3'b000, D4, 1'b1, 1'b0);
        #1;
        chk("t4_dup_set", 256'(dup_err), 256'(1));
        chk("t4_q1", 256'(skip_out[127:64]), 256'(DB));
        step(1'b0, 3'b000, '0, 1'b1, 1'b1);
        step(1'b0, 3'b000, '0, 1'b1, 1'b0);
        #1;
        chk("t4_dup_clr", 256'(dup_err), 256'(0));

        // Reset in the middle of a vector.
        step(1'b1, 3'b001, DA, 1'b1, 1'b0);
        step(1'b1, 3'b010, DA, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 3'b011, D3, 1'b1, 1'b0);
        step(1'b1, 3'b000, D4, 1'b1, 1'b0);
        step(1'b1, 3'b001, D1, 1'b1, 1'b0);
        #1;
        chk("t5_not_early", 256'(skip_valid), 256'(0));
        step(1'b1, 3'b010, D2, 1'b1, 1'b0);
        #1;
        chk("t5_vector", skip_out, v1);

        // Eight back-to-back vectors, consumer always ready.
        ready_drops = 0;
        valid_highs = 0;
        for (int i = 0; i < 32; i++) begin
            if (!slice_ready) ready_drops++;
            if (skip_valid) valid_highs++;
            step(1'b1, 3'((i % 4) + 1), {2{$urandom}}, 1'b1, 1'b0);
        end
        #1;
        chk("t6_ready_drops", 256'(ready_drops), 256'(0));
        // One pulse left over from t5 plus 7 of the 8 new vectors lie before the last edge.
        chk("t6_valid_pulses", 256'(valid_highs), 256'(8));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
